tmr_cntr_bank: RTL and testbench
================================

Name: tmr_cntr_bank

Overview:
- Parametrised multi-channel countdown timer bank for the SDRAM controller.
- Successor to the single 4-bit keep-idle counter; one bank covers tRCD, tRP, tRFC, keep-idle and the refresh interval.
- Each channel loads a timing value, counts down to zero and flags the end. Channels run one-shot or auto-reload.
- Sits beside the main controller FSM: the FSM issues loads and waits on the end flags.

Parameters:
- CW, 4, counter width per channel in bits (≥2).
- NCH, 4, number of independent channels (≥1).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- ld  input  NCH  per-channel load strobe.
- ld_val  input  NCH*CW  load values; channel i uses bits [i*CW+CW-1 : i*CW].
- reload_en  input  NCH  per-channel mode: 1 = auto-reload, 0 = one-shot; sampled every cycle.
- hold  input  NCH  per-channel count freeze.
- cnt_end  output  NCH  level, high while channel count == 0.
- end_pls  output  NCH  registered one-cycle pulse on each expiry.
- any_busy  output  1  OR of ~cnt_end.
- ld_err  output  NCH  sticky load-while-busy error; see Optional Feature.

Behaviour:
- Per-channel state: count[CW-1:0] and rld[CW-1:0] (reload register). Channels are fully independent.
- Reset (sampled high at Clk edge):
  - count = 0, rld = 0, end_pls = 0, ld_err = 0.
  - Hence cnt_end = all 1s and any_busy = 0 the cycle after reset.
  - Reset overrides every other input, including mid-count.
- Per-channel next-state priority, highest first:
  1. Reset.
  2. ld: count <= ld_val slice; rld <= ld_val slice.
  3. hold: count unchanged.
  4. count != 0: count <= count-1.
  5. count == 0 and reload_en == 1 and rld != 0: count <= rld.
  6. Otherwise count stays 0.
- Combinational outputs: cnt_end[i] = (count[i] == 0), directly from the register, no added latency. any_busy follows from cnt_end.
- Timing:
  - One-shot: ld with value N at edge k gives cnt_end high from edge k+N onward (N cycles busy).
  - Auto-reload: period N+1 cycles, with cnt_end high for exactly 1 cycle per period.
- end_pls[i]:
  - Set at the edge where count goes 1→0 by decrement, so it is high in the same cycle cnt_end first rises.
  - Cleared at the next edge.
  - Never set by ld of 0, by reset, or while hold is asserted.
- ld with value 0: count = 0, cnt_end stays/becomes 1, no end_pls. With reload_en = 1, the channel stays idle (rld = 0).
- ld on the same edge as expiry (count == 1): ld wins, no end_pls.
- hold while count == 0 in reload mode suppresses the reload; the reload occurs on the first edge after hold drops.
- Counter never wraps: decrement only when nonzero; no 0→max transitions.
- Changing reload_en mid-count affects only the behaviour at the next zero.

Optional Feature:
- Macro: TMR_LD_ERR_EN.
- Defined:
  - ld_err[i] sets (sticky) when ld[i] is asserted while count[i] != 0 and hold[i] == 0.
  - Auto-reload channels in the cycle they are at 0 are not flagged.
  - Cleared only by Reset. The load itself is still performed.
- Undefined: ld_err tied to all 0s; no extra flops.

Test Plan:
- Reset: hold Reset 3 cycles mid-count (count = 5) → next cycle count = 0, cnt_end = 4'b1111, end_pls = 0, any_busy = 0, ld_err = 0.
- One-shot, CW = 4: ld ch0 with 4'd3 → cnt_end[0] low 3 cycles, then high. end_pls[0] high exactly in the first cycle cnt_end[0] = 1. Other channels unaffected.
- Auto-reload: ld ch1 with 4'd2, reload_en[1] = 1 → count sequence 2,1,0,2,1,0… cnt_end[1] and end_pls[1] pulse every 3 cycles for ≥4 periods.
- Hold and boundaries:
  - ld 4'd4, then hold 2 cycles at count 3 → expiry delayed 2 cycles.
  - ld 4'd0 → no end_pls.
  - ld 4'd15 → 15 cycles busy, no wrap.
- Simultaneous events:
  - ld 4'd6 at the edge where count = 1 → count = 6, no end_pls.
  - NCH = 8, CW = 10 build: all channels loaded with distinct values expire at the correct cycles.
- TMR_LD_ERR_EN defined: ld ch2 while count = 4 → ld_err[2] = 1 and stays 1 until Reset. Macro undefined → ld_err = 0.

Source files
------------

// File: rtl/tmr_cntr_bank_if.sv
// Timer bank bus: load/mode/hold controls from the controller FSM, status flags back.
// Latency: none, signal bundle only.
// Backpressure: none; loads are strobes that the bank always accepts.
//
// Signals (controller -> bank): ld, ld_val (channel i at [i*CW +: CW]), reload_en, hold
// Signals (bank -> controller): cnt_end, end_pls, any_busy, ld_err
interface tmr_cntr_bank_if #(
   parameter int CW  = 4,
   parameter int NCH = 4
);
   logic [NCH-1:0]    ld;
   logic [NCH*CW-1:0] ld_val;
   logic [NCH-1:0]    reload_en;
   logic [NCH-1:0]    hold;
   logic [NCH-1:0]    cnt_end;
   logic [NCH-1:0]    end_pls;
   logic              any_busy;
   logic [NCH-1:0]    ld_err;

   modport master (
      output ld, ld_val, reload_en, hold,
      input  cnt_end, end_pls, any_busy, ld_err
   );

   modport slave (
      input  ld, ld_val, reload_en, hold,
      output cnt_end, end_pls, any_busy, ld_err
   );
endinterface

// File: rtl/tmr_cntr_bank.sv
// Bank of NCH independent CW-bit countdown timers, one-shot or auto-reload per channel.
// Latency: load visible the cycle after the ld edge; cnt_end is combinational from the count.
// Backpressure: none; hold[i] freezes channel i, ld always wins over hold.
//
// Ports: Clk, Reset (synchronous, active high), bus (tmr_cntr_bank_if.slave).
// Optional: define TMR_LD_ERR_EN to enable the sticky load-while-busy flags on ld_err;
//           otherwise ld_err is constant zero and no flops are built for it.
module tmr_cntr_bank #(
   parameter int CW  = 4,
   parameter int NCH = 4
) (
   input logic             Clk,
   input logic             Reset,
   tmr_cntr_bank_if.slave  bus
);

   logic [NCH-1:0] cnt_end_w;
   logic [NCH-1:0] end_pls_w;
   logic [NCH-1:0] ld_err_w;

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_ch
         logic [CW-1:0] count;
         logic [CW-1:0] rld;
         logic          end_pls_q;
         logic [CW-1:0] ld_slice;

         assign ld_slice = bus.ld_val[g*CW +: CW];

         always_ff @(posedge Clk) begin
            if (Reset) begin
               count     <= '0;
               rld       <= '0;
               end_pls_q <= 1'b0;
            end else begin
               end_pls_q <= 1'b0;
               if (bus.ld[g]) begin
                  // A load on the expiry edge pre-empts the pulse.
                  count <= ld_slice;
                  rld   <= ld_slice;
               end else if (bus.hold[g]) begin
                  count <= count;
               end else if (count != '0) begin
                  count     <= count - CW'(1);
                  // Pulse only on a genuine 1->0 decrement.
                  end_pls_q <= (count == CW'(1));
               end else if (bus.reload_en[g] && (rld != '0)) begin
                  count <= rld;
               end
            end
         end

         assign cnt_end_w[g] = (count == '0);
         assign end_pls_w[g] = end_pls_q;

`ifdef TMR_LD_ERR_EN
         logic ld_err_q;

         // A channel sitting at zero (including auto-reload at its zero
         // cycle) or frozen by hold is not considered busy.
         always_ff @(posedge Clk) begin
            if (Reset) begin
               ld_err_q <= 1'b0;
            end else if (bus.ld[g] && (count != '0) && !bus.hold[g]) begin
               ld_err_q <= 1'b1;
            end
         end

         assign ld_err_w[g] = ld_err_q;
`else
         assign ld_err_w[g] = 1'b0;
`endif
      end
   endgenerate

   assign bus.cnt_end  = cnt_end_w;
   assign bus.end_pls  = end_pls_w;
   assign bus.any_busy = ~(&cnt_end_w);
   assign bus.ld_err   = ld_err_w;

endmodule

// File: tb/tb_tmr_cntr_bank.sv
// Directed bench for tmr_cntr_bank: default 4x4-bit bank plus an 8x10-bit bank.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: not applicable.
module tb_tmr_cntr_bank;

   logic Clk;
   logic Reset;

   int n_cmp = 0;
   int n_err = 0;

`ifdef TMR_LD_ERR_EN
   localparam logic [3:0] ERR_EXP = 4'b0101;
`else
   localparam logic [3:0] ERR_EXP = 4'b0000;
`endif

   tmr_cntr_bank_if #(.CW(4),  .NCH(4)) b4 ();
   tmr_cntr_bank_if #(.CW(10), .NCH(8)) b8 ();

   tmr_cntr_bank #(.CW(4),  .NCH(4)) dut4 (.Clk(Clk), .Reset(Reset), .bus(b4));
   tmr_cntr_bank #(.CW(10), .NCH(8)) dut8 (.Clk(Clk), .Reset(Reset), .bus(b8));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_end;
      logic [7:0] exp_pls;

      Reset        = 1'b1;
      b4.ld        = '0;
      b4.ld_val    = '0;
      b4.reload_en = '0;
      b4.hold      = '0;
      b8.ld        = '0;
      b8.ld_val    = '0;
      b8.reload_en = '0;
      b8.hold      = '0;
      tick();
      tick();
      Reset = 1'b0;

      // Reset held 3 cycles while ch0 is counting at 5
      b4.ld_val = 16'h0007;
      b4.ld     = 4'b0001;
      tick();
      b4.ld = '0;
      tick();
      tick();
      check_val("pre_rst_busy", b4.cnt_end, 4'b1110);
      Reset = 1'b1;
      tick();
      check_val("rst_cnt_end", b4.cnt_end, 4'b1111);
      check_val("rst_end_pls", b4.end_pls, 4'b0000);
      check_val("rst_any_busy", b4.any_busy, 1'b0);
      check_val("rst_ld_err", b4.ld_err, 4'b0000);
      tick();
      tick();
      Reset = 1'b0;
      tick();
      check_val("rst_idle", b4.cnt_end, 4'b1111);

      // One-shot ch0 with 3: busy 3 cycles
      b4.ld_val = 16'h0003;
      b4.ld     = 4'b0001;
      tick();
      b4.ld = '0;
      check_val("os_load_end", b4.cnt_end, 4'b1110);
      check_val("os_load_busy", b4.any_busy, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_val($sformatf("os_end_%0d", i), b4.cnt_end, {3'b111, (i >= 3)});
         check_val($sformatf("os_pls_%0d", i), b4.end_pls, {3'b000, (i == 3)});
      end

      // Auto-reload ch1 with 2: period 3, four periods, then one-shot finish
      b4.reload_en = 4'b0010;
      b4.ld_val    = 16'h0020;
      b4.ld        = 4'b0010;
      tick();
      b4.ld = '0;
      check_val("ar_load", b4.cnt_end[1], 1'b0);
      for (int i = 1; i <= 12; i++) begin
         tick();
         check_val($sformatf("ar_end_%0d", i), b4.cnt_end[1], ((i % 3) == 2));
         check_val($sformatf("ar_pls_%0d", i), b4.end_pls, {2'b00, ((i % 3) == 2), 1'b0});
      end
      b4.reload_en = '0;
      tick();
      tick();
      check_val("ar_last_pls", b4.end_pls[1], 1'b1);
      tick();
      check_val("ar_stop_end", b4.cnt_end[1], 1'b1);
      check_val("ar_stop_pls", b4.end_pls[1], 1'b0);

      // Hold ch2 for 2 cycles at count 3: expiry moves from edge 4 to edge 6
      b4.ld_val = 16'h0400;
      b4.ld     = 4'b0100;
      tick();
      b4.ld = '0;
      for (int i = 1; i <= 6; i++) begin
         b4.hold = (i == 2 || i == 3) ? 4'b0100 : 4'b0000;
         tick();
         check_val($sformatf("hold_end_%0d", i), b4.cnt_end[2], (i == 6));
         check_val($sformatf("hold_pls_%0d", i), b4.end_pls[2], (i == 6));
      end
      b4.hold = '0;

      // Load 0 in reload mode: stays idle, no pulse
      b4.reload_en = 4'b0100;
      b4.ld_val    = 16'h0000;
      b4.ld        = 4'b0100;
      tick();
      b4.ld = '0;
      check_val("ld0_end", b4.cnt_end[2], 1'b1);
      check_val("ld0_pls", b4.end_pls[2], 1'b0);
      tick();
      check_val("ld0_end_b", b4.cnt_end[2], 1'b1);
      check_val("ld0_pls_b", b4.end_pls[2], 1'b0);
      b4.reload_en = '0;

      // Load 15 on ch3: 15 cycles busy, no wrap afterwards
      b4.ld_val = 16'hF000;
      b4.ld     = 4'b1000;
      tick();
      b4.ld = '0;
      check_val("ld15_load", b4.cnt_end[3], 1'b0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         check_val($sformatf("ld15_end_%0d", i), b4.cnt_end[3], (i >= 15));
         check_val($sformatf("ld15_pls_%0d", i), b4.end_pls[3], (i == 15));
      end

      // Hold at zero in reload mode delays the reload
      b4.reload_en = 4'b0010;
      b4.ld_val    = 16'h0010;
      b4.ld        = 4'b0010;
      tick();
      b4.ld = '0;
      check_val("hz_load", b4.cnt_end[1], 1'b0);
      tick();
      check_val("hz_pls_1", b4.end_pls[1], 1'b1);
      b4.hold = 4'b0010;
      for (int i = 2; i <= 3; i++) begin
         tick();
         check_val($sformatf("hz_end_%0d", i), b4.cnt_end[1], 1'b1);
         check_val($sformatf("hz_pls_%0d", i), b4.end_pls[1], 1'b0);
      end
      b4.hold = '0;
      tick();
      check_val("hz_reload", b4.cnt_end[1], 1'b0);
      tick();
      check_val("hz_pls_5", b4.end_pls[1], 1'b1);
      b4.reload_en = '0;
      tick();
      check_val("hz_stop_end", b4.cnt_end[1], 1'b1);
      check_val("hz_stop_pls", b4.end_pls[1], 1'b0);

      // Load 6 on ch0 at the edge where count is 1: load wins, no pulse
      b4.ld_val = 16'h0002;
      b4.ld     = 4'b0001;
      tick();
      b4.ld = '0;
      tick();
      b4.ld_val = 16'h0006;
      b4.ld     = 4'b0001;
      tick();
      b4.ld = '0;
      check_val("sim_end", b4.cnt_end[0], 1'b0);
      check_val("sim_pls", b4.end_pls[0], 1'b0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_val($sformatf("sim_end_%0d", i), b4.cnt_end[0], (i == 6));
         check_val($sformatf("sim_pls_%0d", i), b4.end_pls[0], (i == 6));
      end

      // Load ch2 while it is at 4 (flags when enabled); ch3 reloaded under hold (never flags)
      b4.ld_val = 16'h5500;
      b4.ld     = 4'b1100;
      tick();
      b4.ld = '0;
      tick();
      b4.ld_val = 16'h5100;
      b4.ld     = 4'b1100;
      b4.hold   = 4'b1000;
      tick();
      b4.ld   = '0;
      b4.hold = '0;
      tick();
      check_val("err_ld_pls", b4.end_pls[2], 1'b1);
      check_val("err_set", b4.ld_err, ERR_EXP);
      tick();
      tick();
      tick();
      check_val("err_sticky", b4.ld_err, ERR_EXP);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check_val("err_clr", b4.ld_err, 4'b0000);
      check_val("err_clr_end", b4.cnt_end, 4'b1111);
      check_val("err_clr_busy", b4.any_busy, 1'b0);

      // 8 x 10-bit bank: channel i loaded with 3+7*i
      for (int i = 0; i < 8; i++) b8.ld_val[i*10 +: 10] = 10'(3 + 7 * i);
      b8.ld = 8'hFF;
      tick();
      b8.ld = '0;
      check_val("wide_load", b8.cnt_end, 8'h00);
      for (int c = 1; c <= 55; c++) begin
         tick();
         for (int i = 0; i < 8; i++) begin
            exp_end[i] = (c >= 3 + 7 * i);
            exp_pls[i] = (c == 3 + 7 * i);
         end
         check_val($sformatf("wide_end_%0d", c), b8.cnt_end, exp_end);
         check_val($sformatf("wide_pls_%0d", c), b8.end_pls, exp_pls);
      end
      check_val("wide_busy", b8.any_busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
